// File: rtl/wt_cache_pkg.sv
// wt_cache_pkg: shared types and constants for the write-through cache memory arbiter.
package wt_cache_pkg;
  localparam int unsigned ArbSrcTidMaxWidth = 8;
  localparam logic ARB_SRC_ICACHE = 1'b0;
  localparam logic ARB_SRC_DCACHE = 1'b1;
  typedef enum logic {IDLE, WAIT_GNT} arb_state_e;
  typedef struct packed {
    logic                         valid;
    logic                         src;
    logic [ArbSrcTidMaxWidth-1:0] src_tid;
  } tid_entry_t;
endpackage

// File: rtl/wt_tid_table.sv
// wt_tid_table: TID table with lowest-free allocation, indexed lookup and free, full/empty flags.
module wt_tid_table
  import wt_cache_pkg::*;
#(
  parameter int unsigned TidWidth = 3,
  localparam int unsigned NumTid = 2 ** TidWidth
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                alloc_i,
  input  tid_entry_t          alloc_entry_i,
  output logic [TidWidth-1:0] alloc_tid_o,
  output logic                full_o,
  output logic                empty_o,
  input  logic [TidWidth-1:0] lookup_tid_i,
  output tid_entry_t          lookup_o,
  input  logic                free_i
);
  tid_entry_t [NumTid-1:0] tbl_q, tbl_d;
  logic [NumTid-1:0] vld;
  assign lookup_o = tbl_q[lookup_tid_i];
  // Allocation sees only the pre-edge valid vector, so an entry freed this cycle is not reused until the next.
  always_comb begin
    vld = '0;
    alloc_tid_o = '0;
    for (int i = NumTid - 1; i >= 0; i--) begin
      vld[i] = tbl_q[i].valid;
      if (!tbl_q[i].valid) alloc_tid_o = TidWidth'(i);
    end
    full_o = &vld;
    empty_o = ~|vld;
    tbl_d = tbl_q;
    if (free_i && lookup_o.valid) tbl_d[lookup_tid_i].valid = 1'b0;
    if (alloc_i && !full_o) begin
      tbl_d[alloc_tid_o] = alloc_entry_i;
      tbl_d[alloc_tid_o].valid = 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) tbl_q <= '0;
    else tbl_q <= tbl_d;
  end
endmodule

// File: rtl/wt_mem_arbiter.sv
// wt_mem_arbiter: shares one memory request port between I$ and D$ with TID allocation and return routing.
// Define WT_MEM_ARB_DCACHE_PRIO_EN for fixed D$ priority instead of round-robin.
module wt_mem_arbiter
  import wt_cache_pkg::*;
#(
  parameter int unsigned DataWidth   = 128,
  parameter int unsigned SrcTidWidth = 2,
  parameter int unsigned TidWidth    = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   icache_req_i,
  input  logic [SrcTidWidth-1:0] icache_tid_i,
  input  logic [DataWidth-1:0]   icache_data_i,
  output logic                   icache_ack_o,
  input  logic                   dcache_req_i,
  input  logic [SrcTidWidth-1:0] dcache_tid_i,
  input  logic [DataWidth-1:0]   dcache_data_i,
  output logic                   dcache_ack_o,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic [TidWidth-1:0]    mem_tid_o,
  output logic [DataWidth-1:0]   mem_data_o,
  input  logic                   mem_rtrn_vld_i,
  input  logic [TidWidth-1:0]    mem_rtrn_tid_i,
  output logic                   icache_rtrn_vld_o,
  output logic                   dcache_rtrn_vld_o,
  output logic [SrcTidWidth-1:0] rtrn_tid_o,
  output logic                   busy_o,
  output logic                   err_o
);
  arb_state_e state_q, state_d;
  logic rr_q, rr_d;
  logic err_q, err_d;
  logic [TidWidth-1:0] mem_tid_q, mem_tid_d;
  logic [DataWidth-1:0] mem_data_q, mem_data_d;
  logic full, empty, pick, win, hit;
  logic [TidWidth-1:0] alloc_tid;
  tid_entry_t alloc_entry, rtrn_entry;
`ifdef WT_MEM_ARB_DCACHE_PRIO_EN
  assign win = dcache_req_i ? ARB_SRC_DCACHE : ARB_SRC_ICACHE;
`else
  assign win = (icache_req_i && dcache_req_i) ? rr_q : (dcache_req_i ? ARB_SRC_DCACHE : ARB_SRC_ICACHE);
`endif
  assign pick = (state_q == IDLE) && (icache_req_i || dcache_req_i) && !full;
  assign hit = mem_rtrn_vld_i && rtrn_entry.valid;
  assign alloc_entry = '{valid: 1'b1, src: win,
                         src_tid: win ? ArbSrcTidMaxWidth'(dcache_tid_i) : ArbSrcTidMaxWidth'(icache_tid_i)};
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    mem_tid_d = mem_tid_q;
    mem_data_d = mem_data_q;
    err_d = err_q | (mem_rtrn_vld_i & ~rtrn_entry.valid);
    if (pick) begin
      state_d = WAIT_GNT;
      rr_d = ~win;
      mem_tid_d = alloc_tid;
      mem_data_d = win ? dcache_data_i : icache_data_i;
    end else if (state_q == WAIT_GNT && mem_gnt_i) state_d = IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q <= ARB_SRC_ICACHE;
      err_q <= 1'b0;
      mem_tid_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      err_q <= err_d;
      mem_tid_q <= mem_tid_d;
      mem_data_q <= mem_data_d;
    end
  end
  wt_tid_table #(.TidWidth(TidWidth)) u_tid_table (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .alloc_i      (pick),
    .alloc_entry_i(alloc_entry),
    .alloc_tid_o  (alloc_tid),
    .full_o       (full),
    .empty_o      (empty),
    .lookup_tid_i (mem_rtrn_tid_i),
    .lookup_o     (rtrn_entry),
    .free_i       (mem_rtrn_vld_i)
  );
  assign icache_ack_o = pick && (win == ARB_SRC_ICACHE);
  assign dcache_ack_o = pick && (win == ARB_SRC_DCACHE);
  assign mem_req_o = state_q == WAIT_GNT;
  assign mem_tid_o = mem_tid_q;
  assign mem_data_o = mem_data_q;
  assign icache_rtrn_vld_o = hit && (rtrn_entry.src == ARB_SRC_ICACHE);
  assign dcache_rtrn_vld_o = hit && (rtrn_entry.src == ARB_SRC_DCACHE);
  assign rtrn_tid_o = hit ? SrcTidWidth'(rtrn_entry.src_tid) : '0;
  assign busy_o = mem_req_o || !empty;
  assign err_o = err_q;
`ifndef SYNTHESIS
  // Requesters must hold req until acked.
  a_icache_req_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    icache_req_i && !icache_ack_o |=> icache_req_i);
  a_dcache_req_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    dcache_req_i && !dcache_ack_o |=> dcache_req_i);
`endif
endmodule

// File: tb/tb_wt_mem_arbiter.sv
// tb_wt_mem_arbiter: directed plus random checks of wt_mem_arbiter against a transaction-level model.
module tb_wt_mem_arbiter;
  localparam int DW = 128, SW = 2, TW = 3, NT = 8;
`ifdef WT_MEM_ARB_DCACHE_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, ireq, dreq, iack, dack, mreq, gnt, rvld, irtrn, drtrn, busy, err;
  logic [SW-1:0] itid, dtid, rtrn_tid;
  logic [DW-1:0] idata, ddata, mdata;
  logic [TW-1:0] mtid, rtid;
  always #5 clk = ~clk;
  wt_mem_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .icache_req_i(ireq), .icache_tid_i(itid), .icache_data_i(idata), .icache_ack_o(iack),
    .dcache_req_i(dreq), .dcache_tid_i(dtid), .dcache_data_i(ddata), .dcache_ack_o(dack),
    .mem_req_o(mreq), .mem_gnt_i(gnt), .mem_tid_o(mtid), .mem_data_o(mdata),
    .mem_rtrn_vld_i(rvld), .mem_rtrn_tid_i(rtid),
    .icache_rtrn_vld_o(irtrn), .dcache_rtrn_vld_o(drtrn), .rtrn_tid_o(rtrn_tid),
    .busy_o(busy), .err_o(err)
  );
  int n_vec = 0, n_err = 0, n_ia = 0, n_da = 0;
  bit s_iack, s_dack, s_irtrn, s_drtrn;
  logic [SW-1:0] s_rtid;
  // Transaction-level model: a pending request slot, an ownership table and a tie-break owner.
  bit m_wait, m_next_d, m_err;
  logic [TW-1:0] m_tid;
  logic [DW-1:0] m_data;
  bit m_valid [NT];
  bit m_src [NT];
  logic [SW-1:0] m_stid [NT];
  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    int low = -1;
    bit any_v = 0, pick = 0, win = 0, hit = 0;
    #1;
    s_iack = iack; s_dack = dack; s_irtrn = irtrn; s_drtrn = drtrn; s_rtid = rtrn_tid;
    if (!rst) begin
      for (int i = NT - 1; i >= 0; i--) begin
        if (!m_valid[i]) low = i;
        any_v |= m_valid[i];
      end
      pick = !m_wait && (ireq || dreq) && low >= 0;
      win = PRIO ? dreq : ((ireq && dreq) ? m_next_d : dreq);
      hit = rvld && m_valid[rtid];
      chk("icache_ack", iack, pick && !win);
      chk("dcache_ack", dack, pick && win);
      chk("mem_req", mreq, m_wait);
      chk("mem_tid", mtid, m_tid);
      chk("mem_data", mdata, m_data);
      chk("busy", busy, m_wait || any_v);
      chk("err", err, m_err);
      chk("icache_rtrn", irtrn, hit && !m_src[rtid]);
      chk("dcache_rtrn", drtrn, hit && m_src[rtid]);
      chk("rtrn_tid", rtrn_tid, hit ? m_stid[rtid] : 2'd0);
      n_ia += int'(iack);
      n_da += int'(dack);
    end
    @(posedge clk);
    if (rst) begin
      m_wait = 0; m_next_d = 0; m_err = 0; m_tid = '0; m_data = '0;
      foreach (m_valid[i]) begin m_valid[i] = 0; m_src[i] = 0; m_stid[i] = '0; end
    end else begin
      if (rvld && !m_valid[rtid]) m_err = 1;
      if (hit) m_valid[rtid] = 0;
      if (pick) begin
        m_valid[low] = 1; m_src[low] = win; m_stid[low] = win ? dtid : itid;
        m_wait = 1; m_next_d = !win; m_tid = TW'(low); m_data = win ? ddata : idata;
      end else if (m_wait && gnt) m_wait = 0;
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1; ireq = 0; dreq = 0; gnt = 0; rvld = 0; rtid = '0;
    itid = '0; dtid = '0; idata = '0; ddata = '0;
    tick(); tick();
    rst = 0;
  endtask
  initial begin
    do_reset();
    chk("rst_mem_req", mreq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_data", mdata, 0);
    // Single I$ request through grant and return
    ireq = 1; itid = 2'd1; idata = rnd();
    tick();
    chk("t1_ack", s_iack, 1);
    ireq = 0;
    chk("t1_mem_req", mreq, 1);
    chk("t1_mem_tid", mtid, 0);
    gnt = 1; tick(); gnt = 0;
    rvld = 1; rtid = 3'd0; tick(); rvld = 0;
    chk("t1_irtrn", s_irtrn, 1);
    chk("t1_rtid", s_rtid, 1);
    chk("t1_busy", busy, 0);
    // Both requesting continuously; eight grants fill the table
    do_reset();
    n_ia = 0; n_da = 0;
    ireq = 1; dreq = 1; gnt = 1; itid = 2'($urandom); dtid = 2'($urandom); idata = rnd(); ddata = rnd();
    for (int c = 0; c < 40 && n_ia + n_da < 8; c++) begin
      tick();
      if (s_iack) begin itid = 2'($urandom); idata = rnd(); end
      if (s_dack) begin dtid = 2'($urandom); ddata = rnd(); end
    end
    chk("arb_icache_grants", n_ia, PRIO ? 0 : 4);
    chk("arb_dcache_grants", n_da, PRIO ? 8 : 4);
    dreq = 0;
    repeat (3) tick();
    chk("full_no_ack", n_ia, PRIO ? 0 : 4);
    chk("full_busy", busy, 1);
    rvld = 1; rtid = 3'd3; tick(); rvld = 0;
    chk("free3_same_cycle_ack", s_iack, 0);
    tick();
    chk("free3_ack", s_iack, 1);
    chk("free3_mem_tid", mtid, 3);
    ireq = 0;
    tick();
    // Free and request in the same cycle with only TID 5 becoming free
    dreq = 1; dtid = 2'd2; ddata = rnd(); rvld = 1; rtid = 3'd5;
    tick(); rvld = 0;
    chk("free5_same_cycle_ack", s_dack, 0);
    tick();
    chk("free5_ack", s_dack, 1);
    chk("free5_mem_tid", mtid, 5);
    dreq = 0;
    tick();
    // Return on a never-allocated TID
    do_reset();
    rvld = 1; rtid = 3'd6; tick(); rvld = 0;
    chk("unalloc_strobe", s_irtrn | s_drtrn, 0);
    chk("unalloc_err", err, 1);
    repeat (3) tick();
    chk("err_sticky", err, 1);
    // Reset while waiting for grant with three TIDs allocated
    do_reset();
    ireq = 1; gnt = 1; idata = rnd();
    repeat (4) tick();
    gnt = 0; tick(); ireq = 0; tick();
    chk("pre_rst_mem_req", mreq, 1);
    rst = 1; tick(); rst = 0;
    chk("post_rst_mem_req", mreq, 0);
    chk("post_rst_busy", busy, 0);
    rvld = 1; rtid = 3'd1; tick(); rvld = 0;
    chk("post_rst_rtrn", s_irtrn | s_drtrn, 0);
    chk("post_rst_err", err, 1);
    // Random traffic respecting the hold-until-ack protocol
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (!ireq || s_iack) begin ireq = 1'($urandom); itid = 2'($urandom); idata = rnd(); end
      if (!dreq || s_dack) begin dreq = 1'($urandom); dtid = 2'($urandom); ddata = rnd(); end
      gnt = $urandom_range(0, 2) != 0;
      rvld = $urandom_range(0, 2) == 0;
      rtid = 3'($urandom);
      for (int k = 0; k < 6 && !m_valid[rtid]; k++) rtid = 3'($urandom);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
